unidade_controle_partida: RTL
=============================

Name: unidade_controle_partida

Overview:
Moore FSM that sequences the game datapath (fluxo_dados) through one complete match.
- Seed capture, then role reveal per player.
- Night actions per living player, then elimination evaluation.
- Day vote and execution, then win detection.
Drives every datapath strobe. Consumes the datapath status flags plus two single-cycle button pulses that are edge-detected at top level.

Parameters:
- TIMEOUT_CICLOS, 1000, cycles allowed per night action / day vote (used only with the optional feature).
- TW, 10, width of the timeout counter.

Ports:
- clock  in  1  system clock
- rst_global  in  1  synchronous active-high reset
- iniciar  in  1  one-cycle pulse: start / restart match
- confirma  in  1  one-cycle pulse: player confirms choice
- CJ_fim  in  1  player counter at last player (4)
- jogador_vivo  in  1  current player alive
- votou  in  1  datapath accepted vote (valid one cycle after voto)
- acertou  in  1  voted player is the wolf
- sinal_lobo_ganhou  in  1  three deaths reached
- zera_CS, zera_CJ, inc_seed, e_seed_reg, inc_jogador  out  1  counter/seed-register controls
- mostra_classe, processar_acao, avaliar_eliminacao, voto, morra  out  1  datapath strobes
- limpa_jogo  out  1  clears match state; ORed with rst_global at top level
- fase_noite  out  1  1 during night states
- fim_jogo  out  1  match over
- vencedor  out  2  00 none, 01 wolf, 10 villagers
- timeout  out  1  one-cycle pulse on expiry (0 without feature)
- db_estado  out  5  state code

Behaviour:
- Reset: rst_global in any state → INICIAL next cycle. Reset has priority over all inputs. All outputs are 0 except those INICIAL drives.
- Outputs are decoded from the state only (Moore). Each strobe is asserted for exactly one cycle per state visit.
- States, code, outputs, transitions:
  - 0 INICIAL: zera_CS, zera_CJ, limpa_jogo → ESPERA.
  - 1 ESPERA: inc_seed every cycle (entropy source). iniciar → CARREGA.
  - 2 CARREGA: e_seed_reg, zera_CJ → MOSTRA.
  - 3 MOSTRA: mostra_classe. confirma → PROX_MOSTRA.
  - 4 PROX_MOSTRA: CJ_fim → zera_CJ, go NOITE_JOG. Otherwise inc_jogador, go MOSTRA.
  - 5 NOITE_JOG (fase_noite): !jogador_vivo → PROX_NOITE immediately. Otherwise confirma → PROCESSA.
  - 6 PROCESSA (fase_noite): processar_acao → PROX_NOITE. Villagers also confirm, so roles stay hidden.
  - 7 PROX_NOITE (fase_noite): CJ_fim → AVALIA. Otherwise inc_jogador, go NOITE_JOG.
  - 8 AVALIA: avaliar_eliminacao, zera_CJ → VERIFICA_NOITE.
  - 9 VERIFICA_NOITE: sinal_lobo_ganhou → LOBO_VENCE. Otherwise → DIA_VOTO. Flag is read one cycle after the death write.
  - 10 DIA_VOTO: confirma → REGISTRA_VOTO.
  - 11 REGISTRA_VOTO: voto → CHECA_VOTO.
  - 12 CHECA_VOTO: votou → ELIMINA. Otherwise → DIA_VOTO (vote for a dead player is rejected and retried).
  - 13 ELIMINA: morra → VERIFICA_DIA.
  - 14 VERIFICA_DIA: priority acertou → ALDEOES_VENCEM, then sinal_lobo_ganhou → LOBO_VENCE, else zera_CJ and go NOITE_JOG.
  - 15 ALDEOES_VENCEM: fim_jogo, vencedor=10. iniciar → INICIAL.
  - 16 LOBO_VENCE: fim_jogo, vencedor=01. iniciar → INICIAL.
- Input handling: iniciar is ignored outside ESPERA and the end states. confirma is ignored outside MOSTRA, NOITE_JOG and DIA_VOTO. When both arrive in the same cycle, only the one meaningful in the current state acts.
- Unused codes 17–31 → INICIAL.

Optional Feature:
PARTIDA_TIMEOUT_EN
- With the macro:
  - A TW-bit counter clears on entering NOITE_JOG or DIA_VOTO and counts while in either state.
  - Reaching TIMEOUT_CICLOS-1 pulses timeout.
  - In NOITE_JOG it moves to PROX_NOITE with no processar_acao.
  - In DIA_VOTO it moves to NOITE_JOG with zera_CJ: day skipped, no death.
  - If confirma and expiry coincide, confirma wins.
- Without the macro: states wait indefinitely, timeout is tied to 0, and no counter is instantiated.

Decomposition:
- Shared package partida_pkg: 5-bit state code constants (0–16), class codes (ALDEAO=00, LOBO=01, MEDICO=10), vencedor codes.
- One sub-module: reuse contador_m (M=TIMEOUT_CICLOS, N=TW) as the timeout counter, present only under PARTIDA_TIMEOUT_EN.

Test Plan:
- Reset → db_estado=0 for one cycle then 1 with inc_seed high. Pulse iniciar after 7 cycles → e_seed_reg high exactly one cycle, state 3.
- Five confirma pulses in MOSTRA → inc_jogador pulses 4 times, zera_CJ once, state 5 with fase_noite=1.
- Night with jogador_vivo=0 for player 2 → that player skipped with no processar_acao. Four processar_acao pulses total, then avaliar_eliminacao once.
- Day: votou=0 on first check → returns to state 10. Second vote with votou=1, acertou=1 → morra pulse, then state 15, vencedor=10, fim_jogo=1.
- sinal_lobo_ganhou=1 at VERIFICA_NOITE → state 16, vencedor=01. Then iniciar → INICIAL with limpa_jogo=1.
- rst_global asserted in state 11 → state 0 next cycle, voto never asserted. With PARTIDA_TIMEOUT_EN and TIMEOUT_CICLOS=8: idle in DIA_VOTO → timeout pulse at cycle 8, state 5, no morra.

Source files
------------

// File: rtl/partida_pkg.sv
//------------------------------------------------------------------------------
// Module : partida_pkg
// Brief  : Shared state, class and winner codes for the match controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package partida_pkg;

    typedef enum logic [4:0] {
        INICIAL        = 5'd0,
        ESPERA         = 5'd1,
        CARREGA        = 5'd2,
        MOSTRA         = 5'd3,
        PROX_MOSTRA    = 5'd4,
        NOITE_JOG      = 5'd5,
        PROCESSA       = 5'd6,
        PROX_NOITE     = 5'd7,
        AVALIA         = 5'd8,
        VERIFICA_NOITE = 5'd9,
        DIA_VOTO       = 5'd10,
        REGISTRA_VOTO  = 5'd11,
        CHECA_VOTO     = 5'd12,
        ELIMINA        = 5'd13,
        VERIFICA_DIA   = 5'd14,
        ALDEOES_VENCEM = 5'd15,
        LOBO_VENCE     = 5'd16
    } estado_t;

    typedef enum logic [1:0] {
        ALDEAO = 2'b00,
        LOBO   = 2'b01,
        MEDICO = 2'b10
    } classe_t;

    typedef enum logic [1:0] {
        VENC_NENHUM  = 2'b00,
        VENC_LOBO    = 2'b01,
        VENC_ALDEOES = 2'b10
    } vencedor_t;

endpackage

`default_nettype wire

// File: rtl/unidade_controle_partida_if.sv
//------------------------------------------------------------------------------
// Module : unidade_controle_partida_if
// Brief  : Controller <-> datapath/button bundle (status in, strobes out).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface unidade_controle_partida_if;

    logic       iniciar;
    logic       confirma;
    logic       CJ_fim;
    logic       jogador_vivo;
    logic       votou;
    logic       acertou;
    logic       sinal_lobo_ganhou;

    logic       zera_CS;
    logic       zera_CJ;
    logic       inc_seed;
    logic       e_seed_reg;
    logic       inc_jogador;
    logic       mostra_classe;
    logic       processar_acao;
    logic       avaliar_eliminacao;
    logic       voto;
    logic       morra;
    logic       limpa_jogo;
    logic       fase_noite;
    logic       fim_jogo;
    logic [1:0] vencedor;
    logic       timeout;
    logic [4:0] db_estado;

    modport master (
        input  iniciar, confirma, CJ_fim, jogador_vivo, votou, acertou, sinal_lobo_ganhou,
        output zera_CS, zera_CJ, inc_seed, e_seed_reg, inc_jogador, mostra_classe,
               processar_acao, avaliar_eliminacao, voto, morra, limpa_jogo,
               fase_noite, fim_jogo, vencedor, timeout, db_estado
    );

    modport slave (
        output iniciar, confirma, CJ_fim, jogador_vivo, votou, acertou, sinal_lobo_ganhou,
        input  zera_CS, zera_CJ, inc_seed, e_seed_reg, inc_jogador, mostra_classe,
               processar_acao, avaliar_eliminacao, voto, morra, limpa_jogo,
               fase_noite, fim_jogo, vencedor, timeout, db_estado
    );

endinterface

`default_nettype wire

// File: rtl/contador_m.sv
//------------------------------------------------------------------------------
// Module : contador_m
// Brief  : Modulo-M counter with sync clear; only built with PARTIDA_TIMEOUT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifdef PARTIDA_TIMEOUT_EN
module contador_m #(
    parameter int M = 1000,
    parameter int N = 10
) (
    input  wire logic clock,
    input  wire logic zera,
    input  wire logic conta,
    output logic      fim
);

    logic [N-1:0] q_q;

    always_ff @(posedge clock) begin
        if (zera)
            q_q <= '0;
        else if (conta)
            q_q <= (q_q == N'(M - 1)) ? '0 : q_q + 1'b1;
    end

    assign fim = (q_q == N'(M - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/unidade_controle_partida.sv
//------------------------------------------------------------------------------
// Module : unidade_controle_partida
// Brief  : Moore FSM sequencing one match; PARTIDA_TIMEOUT_EN adds wait timeouts.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module unidade_controle_partida
    import partida_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int TW             = 10
) (
    input  wire logic                  clock,
    input  wire logic                  rst_global,
    unidade_controle_partida_if.master bus
);

    estado_t state_q, state_d;
    logic    expira_w;

    if (TIMEOUT_CICLOS < 2 || TIMEOUT_CICLOS > (1 << TW)) begin : g_cfg_invalida
        $error("TIMEOUT_CICLOS does not fit in TW bits");
    end

    always_ff @(posedge clock) begin
        if (rst_global)
            state_q <= INICIAL;
        else
            state_q <= state_d;
    end

`ifdef PARTIDA_TIMEOUT_EN
    logic espera_w, zera_cnt_w, fim_cnt_w;

    // Clearing on any state change restarts the window when DIA_VOTO jumps straight to NOITE_JOG.
    assign espera_w   = (state_q == NOITE_JOG) || (state_q == DIA_VOTO);
    assign zera_cnt_w = rst_global || !espera_w || (state_d != state_q);

    contador_m #(
        .M(TIMEOUT_CICLOS),
        .N(TW)
    ) u_timeout (
        .clock(clock),
        .zera (zera_cnt_w),
        .conta(espera_w),
        .fim  (fim_cnt_w)
    );

    assign expira_w = espera_w && fim_cnt_w;
`else
    assign expira_w = 1'b0;
`endif

    always_comb begin
        state_d                = state_q;
        bus.zera_CS            = 1'b0;
        bus.zera_CJ            = 1'b0;
        bus.inc_seed           = 1'b0;
        bus.e_seed_reg         = 1'b0;
        bus.inc_jogador        = 1'b0;
        bus.mostra_classe      = 1'b0;
        bus.processar_acao     = 1'b0;
        bus.avaliar_eliminacao = 1'b0;
        bus.voto               = 1'b0;
        bus.morra              = 1'b0;
        bus.limpa_jogo         = 1'b0;
        bus.fase_noite         = 1'b0;
        bus.fim_jogo           = 1'b0;
        bus.vencedor           = VENC_NENHUM;
        bus.timeout            = 1'b0;
        bus.db_estado          = state_q;

        // Strobes are suppressed while reset is held so an interrupted state never fires.
        if (!rst_global) begin
            case (state_q)
                INICIAL: begin
                    bus.zera_CS    = 1'b1;
                    bus.zera_CJ    = 1'b1;
                    bus.limpa_jogo = 1'b1;
                    state_d        = ESPERA;
                end
                ESPERA: begin
                    bus.inc_seed = 1'b1;
                    if (bus.iniciar) state_d = CARREGA;
                end
                CARREGA: begin
                    bus.e_seed_reg = 1'b1;
                    bus.zera_CJ    = 1'b1;
                    state_d        = MOSTRA;
                end
                MOSTRA: begin
                    bus.mostra_classe = 1'b1;
                    if (bus.confirma) state_d = PROX_MOSTRA;
                end
                PROX_MOSTRA: begin
                    if (bus.CJ_fim) begin
                        bus.zera_CJ = 1'b1;
                        state_d     = NOITE_JOG;
                    end else begin
                        bus.inc_jogador = 1'b1;
                        state_d         = MOSTRA;
                    end
                end
                NOITE_JOG: begin
                    bus.fase_noite = 1'b1;
                    if (!bus.jogador_vivo) begin
                        state_d = PROX_NOITE;
                    end else if (bus.confirma) begin
                        state_d = PROCESSA;
                    end else if (expira_w) begin
                        bus.timeout = 1'b1;
                        state_d     = PROX_NOITE;
                    end
                end
                PROCESSA: begin
                    bus.fase_noite     = 1'b1;
                    bus.processar_acao = 1'b1;
                    state_d            = PROX_NOITE;
                end
                PROX_NOITE: begin
                    bus.fase_noite = 1'b1;
                    if (bus.CJ_fim) begin
                        state_d = AVALIA;
                    end else begin
                        bus.inc_jogador = 1'b1;
                        state_d         = NOITE_JOG;
                    end
                end
                AVALIA: begin
                    bus.avaliar_eliminacao = 1'b1;
                    bus.zera_CJ            = 1'b1;
                    state_d                = VERIFICA_NOITE;
                end
                VERIFICA_NOITE: begin
                    state_d = bus.sinal_lobo_ganhou ? LOBO_VENCE : DIA_VOTO;
                end
                DIA_VOTO: begin
                    if (bus.confirma) begin
                        state_d = REGISTRA_VOTO;
                    end else if (expira_w) begin
                        bus.timeout = 1'b1;
                        bus.zera_CJ = 1'b1;
                        state_d     = NOITE_JOG;
                    end
                end
                REGISTRA_VOTO: begin
                    bus.voto = 1'b1;
                    state_d  = CHECA_VOTO;
                end
                CHECA_VOTO: begin
                    state_d = bus.votou ? ELIMINA : DIA_VOTO;
                end
                ELIMINA: begin
                    bus.morra = 1'b1;
                    state_d   = VERIFICA_DIA;
                end
                VERIFICA_DIA: begin
                    if (bus.acertou) begin
                        state_d = ALDEOES_VENCEM;
                    end else if (bus.sinal_lobo_ganhou) begin
                        state_d = LOBO_VENCE;
                    end else begin
                        bus.zera_CJ = 1'b1;
                        state_d     = NOITE_JOG;
                    end
                end
                ALDEOES_VENCEM: begin
                    bus.fim_jogo = 1'b1;
                    bus.vencedor = VENC_ALDEOES;
                    if (bus.iniciar) state_d = INICIAL;
                end
                LOBO_VENCE: begin
                    bus.fim_jogo = 1'b1;
                    bus.vencedor = VENC_LOBO;
                    if (bus.iniciar) state_d = INICIAL;
                end
                default: state_d = INICIAL;
            endcase
        end
    end

endmodule

`default_nettype wire
